// File: rtl/io_pkg.sv
// Shared constants for the MMIO IO responder: register offsets and status bit positions.
package io_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SW_W   = 16;

    localparam logic [1:0] IO_STATUS   = 2'b00;
    localparam logic [1:0] IO_SWDATA   = 2'b01;
    localparam logic [1:0] IO_LEDDATA  = 2'b10;
    localparam logic [1:0] IO_RESERVED = 2'b11;

    localparam int unsigned ST_LED_READY = 0;
    localparam int unsigned ST_SW_READY  = 1;

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> 2-flop synchronizer -> optional debouncer (DEBOUNCE_EN) -> one-cycle rising-edge pulse.
module btn_conditioner #(
    parameter logic [19:0] DB_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic       s1;
    logic       s2;
    logic       filt;
    logic       prev;
    logic       armed;
    logic [1:0] vld;

    // armed only once a genuinely sampled low has been seen, so a button held through reset cannot fire
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            vld   <= 2'b00;
            armed <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            vld   <= {vld[0], 1'b1};
            armed <= armed | (vld[1] & ~s2);
            prev  <= filt;
            pulse <= armed & filt & ~prev;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(int'(DB_CYCLES) + 1);

    logic [CNT_W-1:0] cnt;

    // filtered level follows s2 only after DB_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (s2 != filt) begin
            if (cnt == CNT_W'(DB_CYCLES - 20'd1)) begin
                cnt  <= '0;
                filt <= s2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    logic unused_db;

    assign filt      = s2;
    assign unused_db = ^DB_CYCLES;
`endif

endmodule

// File: rtl/mmio_io_responder.sv
// MMIO peripheral responder: button/ready handshake, switch capture and LED register.
// Optional debounce of the buttons is enabled with DEBOUNCE_EN.
module mmio_io_responder
    import io_pkg::*;
#(
    parameter logic [19:0] DB_CYCLES = 20'd500000,
    parameter int unsigned LED_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pRead,
    input  logic              pWrite,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    input  logic              btnL,
    input  logic              btnR,
    input  logic [SW_W-1:0]   switch,
    output logic [LED_W-1:0]  led
);

    logic            btnl_p;
    logic            btnr_p;
    logic [SW_W-1:0] sw_s1;
    logic [SW_W-1:0] sw_s2;
    logic [SW_W-1:0] sw_cap;
    logic            sw_ready;
    logic            led_ready;
    logic            sw_rd;
    logic            led_wr;
    logic            unused_wdata;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btnl (
        .clk   (clk),
        .reset (reset),
        .raw   (btnL),
        .pulse (btnl_p)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btnr (
        .clk   (clk),
        .reset (reset),
        .raw   (btnR),
        .pulse (btnr_p)
    );

    assign sw_rd        = pRead & (addr == IO_SWDATA);
    assign led_wr       = pWrite & (addr == IO_LEDDATA);
    assign unused_wdata = ^writeData[DATA_W-1:LED_W];

    // set events win over the clearing read/write in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1     <= '0;
            sw_s2     <= '0;
            sw_cap    <= '0;
            sw_ready  <= 1'b0;
            led_ready <= 1'b0;
            led       <= '0;
        end else begin
            sw_s1 <= switch;
            sw_s2 <= sw_s1;
            if (btnr_p) begin
                sw_cap   <= sw_s2;
                sw_ready <= 1'b1;
            end else if (sw_rd) begin
                sw_ready <= 1'b0;
            end
            if (led_wr) begin
                led <= writeData[LED_W-1:0];
            end
            if (btnl_p) begin
                led_ready <= 1'b1;
            end else if (led_wr) begin
                led_ready <= 1'b0;
            end
        end
    end

    // read mux reflects pre-edge state
    always_comb begin
        readData = '0;
        if (pRead) begin
            case (addr)
                IO_STATUS: begin
                    readData[ST_LED_READY] = led_ready;
                    readData[ST_SW_READY]  = sw_ready;
                end
                IO_SWDATA: readData = DATA_W'(sw_cap);
                default:   readData = '0;
            endcase
        end
    end

endmodule
